// File: rtl/dilated_stack_sequencer.sv
// Sequences one 4-channel sample through a stack of dilated causal conv1d layers,
// owning per-layer history rings and driving a shared conv engine. Optional CONV_WATCHDOG_EN.
module dilated_stack_sequencer #(
  parameter int W          = 16,
  parameter int NUM_LAYERS = 3,
  parameter int DILATION   = 4,
  parameter int HIST_DEPTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_v,
  output logic                          in_rdy,
  input  logic [4*W-1:0]                in_d,
  output logic                          out_v,
  input  logic                          out_rdy,
  output logic [4*W-1:0]                out_d,
  output logic [$clog2(NUM_LAYERS)-1:0] eng_layer,
  output logic                          eng_rst,
  output logic                          eng_relu,
  output logic [16*W-1:0]               eng_a,
  input  logic                          eng_out_v,
  input  logic [4*W-1:0]                eng_out,
  output logic                          err
);

  localparam int PW = $clog2(HIST_DEPTH);
  localparam int LW = $clog2(NUM_LAYERS);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_ACCEPT, S_START, S_RUN, S_WB, S_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     clr_q, clr_d;
  logic [LW-1:0]     layer_q, layer_d;
  logic              relu_q, relu_d;
  logic [16*W-1:0]   a_q, a_d;
  logic [4*W-1:0]    res_q, res_d;
  logic              first_q, first_d;
  logic              out_v_q, out_v_d;
  logic [4*W-1:0]    out_d_q, out_d_d;
  logic              err_q, err_d;
`ifdef CONV_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     wd_q, wd_d;
`endif

  logic [4*W-1:0]    hist [NUM_LAYERS][HIST_DEPTH];
  logic              clr_we, hist_we;
  logic [LW-1:0]     hist_wl;
  logic [4*W-1:0]    hist_wd;

  logic [31:0]       layer_ext;
  int unsigned       dil;
  logic [PW-1:0]     tap_idx;

  assign layer_ext = 32'(layer_q);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    clr_d   = clr_q;
    layer_d = layer_q;
    relu_d  = relu_q;
    a_d     = a_q;
    res_d   = res_q;
    first_d = first_q;
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    err_d   = err_q;
`ifdef CONV_WATCHDOG_EN
    wd_d    = wd_q;
`endif
    clr_we  = 1'b0;
    hist_we = 1'b0;
    hist_wl = '0;
    hist_wd = '0;
    dil     = 1;
    tap_idx = '0;

    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        clr_d  = clr_q + PW'(1);
        if (clr_q == PW'(HIST_DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (in_v) begin
          hist_we = 1'b1;
          hist_wd = in_d;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        layer_d = '0;
        state_d = S_START;
      end
      S_START: begin
        // dil = DILATION**layer built from constant multiplies
        for (int unsigned i = 0; i < NUM_LAYERS - 1; i++)
          if (i < layer_ext) dil = dil * DILATION;
        for (int unsigned k = 0; k < 4; k++) begin
          tap_idx = wp_q - PW'((3 - k) * dil);
          a_d[k*4*W +: 4*W] = hist[layer_q][tap_idx];
        end
        relu_d  = (layer_q != LW'(NUM_LAYERS - 1));
        first_d = 1'b1;
`ifdef CONV_WATCHDOG_EN
        wd_d    = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        first_d = 1'b0;
`ifdef CONV_WATCHDOG_EN
        wd_d = wd_q + TW'(1);
`endif
        if (!first_q && eng_out_v) begin
          res_d   = eng_out;
          state_d = S_WB;
        end
`ifdef CONV_WATCHDOG_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_WB;
        end
`endif
      end
      S_WB: begin
        if (layer_q != LW'(NUM_LAYERS - 1)) begin
          hist_we = 1'b1;
          hist_wl = layer_q + LW'(1);
          hist_wd = res_q;
          layer_d = layer_q + LW'(1);
          state_d = S_START;
        end else begin
          out_d_d = res_q;
          out_v_d = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_rdy) begin
          out_v_d = 1'b0;
          wp_d    = wp_q + PW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      wp_q    <= '0;
      clr_q   <= '0;
      layer_q <= '0;
      relu_q  <= 1'b0;
      a_q     <= '0;
      res_q   <= '0;
      first_q <= 1'b0;
      out_v_q <= 1'b0;
      out_d_q <= '0;
      err_q   <= 1'b0;
`ifdef CONV_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      clr_q   <= clr_d;
      layer_q <= layer_d;
      relu_q  <= relu_d;
      a_q     <= a_d;
      res_q   <= res_d;
      first_q <= first_d;
      out_v_q <= out_v_d;
      out_d_q <= out_d_d;
      err_q   <= err_d;
`ifdef CONV_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // History rings carry no reset; the CLEAR pass zeroes them after every reset.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
      if (clr_we) hist[l][clr_q] <= '0;
      else if (hist_we && hist_wl == LW'(l)) hist[l][wp_q] <= hist_wd;
    end
  end

  assign in_rdy    = (state_q == S_IDLE);
  assign eng_rst   = (state_q != S_RUN);
  assign eng_layer = layer_q;
  assign eng_relu  = relu_q;
  assign eng_a     = a_q;
  assign out_v     = out_v_q;
  assign out_d     = out_d_q;
`ifdef CONV_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
